// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, field positions and the reset PRId value.
// Also provides the SR/Cause packing helpers used by the read mux.
package cp0_pkg;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam int IM_LO   = 10;
  localparam int IM_HI   = 15;
  localparam int EXL_BIT = 1;
  localparam int IE_BIT  = 0;

  localparam logic [31:0] PRID_DEFAULT = 32'h0000_3000;

  function automatic logic [31:0] pack_sr(input logic [5:0] im, input logic exl,
                                          input logic ie);
    logic [31:0] v;
    v = '0;
    v[IM_HI:IM_LO] = im;
    v[EXL_BIT]     = exl;
    v[IE_BIT]      = ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic [5:0] ip);
    logic [31:0] v;
    v = '0;
    v[IM_HI:IM_LO] = ip;
    return v;
  endfunction

endpackage

// File: rtl/cp0_sync2.sv
// Two-flop synchroniser for the asynchronous device interrupt lines.
// Output is registered; a change on d appears on q after the second edge.
module cp0_sync2 #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC, PRId plus hardware interrupt request.
// Handles mtc0/mfc0, interrupt entry (EPC capture, EXL set) and eret.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL  = PRID_DEFAULT,
  parameter int          NUM_HWINT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [29:0]          pc,
  input  logic [31:0]          din,
  input  logic [4:0]           sel,
  input  logic                 we,
  input  logic                 exl_set,
  input  logic                 exl_clr,
  input  logic [NUM_HWINT-1:0] hwint,
  output logic                 int_req,
  output logic [29:0]          epc,
  output logic [31:0]          dout
);

  logic [5:0]  im_reg, im_next;
  logic        exl_reg, exl_next;
  logic        ie_reg, ie_next;
  logic [29:0] epc_reg, epc_next;
  logic [NUM_HWINT-1:0] ip;

  cp0_sync2 #(.WIDTH(NUM_HWINT)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (hwint),
    .q   (ip)
  );

  // Later assignments override earlier ones, so the order here encodes the
  // priority: mtc0 < eret < interrupt entry.
  always_comb begin
    im_next  = im_reg;
    exl_next = exl_reg;
    ie_next  = ie_reg;
    epc_next = epc_reg;
    if (we && sel == CP0_SR) begin
      im_next  = din[IM_HI:IM_LO];
      exl_next = din[EXL_BIT];
      ie_next  = din[IE_BIT];
    end
    if (we && sel == CP0_EPC) begin
      epc_next = din[31:2];
    end
    if (exl_clr) begin
      exl_next = 1'b0;
    end
    if (exl_set) begin
      exl_next = 1'b1;
      epc_next = pc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      im_reg  <= '0;
      exl_reg <= 1'b0;
      ie_reg  <= 1'b0;
      epc_reg <= '0;
    end else begin
      im_reg  <= im_next;
      exl_reg <= exl_next;
      ie_reg  <= ie_next;
      epc_reg <= epc_next;
    end
  end

  assign int_req = (|(ip & im_reg)) & ie_reg & ~exl_reg;
  assign epc     = epc_reg;

  always_comb begin
    dout = '0;
    case (sel)
      CP0_SR:    dout = pack_sr(im_reg, exl_reg, ie_reg);
      CP0_CAUSE: dout = pack_cause(ip);
      CP0_EPC:   dout = {epc_reg, 2'b00};
      CP0_PRID:  dout = PRID_VAL;
      default:   dout = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed plus randomized bench for cp0_unit against a register-level model.
// The model applies the architectural update rules directly at each edge.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [29:0] pc = '0;
  logic [31:0] din = '0;
  logic [4:0]  sel = '0;
  logic        we = 1'b0;
  logic        exl_set = 1'b0;
  logic        exl_clr = 1'b0;
  logic [5:0]  hwint = '0;
  logic        int_req;
  logic [29:0] epc;
  logic [31:0] dout;

  int n_cmp = 0;
  int n_err = 0;
  int n_txn = 0;

  // architectural model
  logic [5:0]  m_im, m_ip, m_hw_seen;
  logic        m_exl, m_ie;
  logic [29:0] m_epc;

  cp0_unit dut (
    .clk     (clk),
    .rst     (rst),
    .pc      (pc),
    .din     (din),
    .sel     (sel),
    .we      (we),
    .exl_set (exl_set),
    .exl_clr (exl_clr),
    .hwint   (hwint),
    .int_req (int_req),
    .epc     (epc),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [4:0] s);
    case (s)
      5'd12:   return {16'h0, m_im, 8'h0, m_exl, m_ie};
      5'd13:   return {16'h0, m_ip, 10'h0};
      5'd14:   return {m_epc, 2'b00};
      5'd15:   return 32'h0000_3000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_int();
    return (|(m_ip & m_im)) && m_ie && !m_exl;
  endfunction

  task automatic model_reset();
    m_im = '0; m_ip = '0; m_hw_seen = '0;
    m_exl = 1'b0; m_ie = 1'b0; m_epc = '0;
  endtask

  // One rising edge worth of architectural effect, from pre-edge inputs/state.
  task automatic model_edge();
    logic       sr_wr, epc_wr;
    logic       exl_new;
    logic [29:0] epc_new;
    sr_wr  = we && sel == 5'd12;
    epc_wr = we && sel == 5'd14;
    if (exl_set)      exl_new = 1'b1;
    else if (exl_clr) exl_new = 1'b0;
    else if (sr_wr)   exl_new = din[1];
    else              exl_new = m_exl;
    if (exl_set)      epc_new = pc;
    else if (epc_wr)  epc_new = din[31:2];
    else              epc_new = m_epc;
    if (sr_wr) begin
      m_im = din[15:10];
      m_ie = din[0];
    end
    m_exl = exl_new;
    m_epc = epc_new;
    m_ip = m_hw_seen;      // device level seen two edges ago
    m_hw_seen = hwint;
  endtask

  task automatic check_all(input string tag);
    logic [4:0] other;
    check_val({tag, ".int_req"}, 32'(int_req), 32'(m_int()));
    check_val({tag, ".epc"}, 32'(epc), 32'(m_epc));
    for (int s = 12; s <= 15; s++) begin
      sel = 5'(s);
      #1;
      check_val($sformatf("%s.rd%0d", tag, s), dout, m_read(5'(s)));
    end
    other = 5'($urandom_range(0, 27));
    if (other >= 5'd12) other = other + 5'd4;
    sel = other;
    #1;
    check_val({tag, ".rd_other"}, dout, 32'h0);
  endtask

  task automatic cycle(input logic w, input logic [4:0] s, input logic [31:0] d,
                       input logic es, input logic ec, input logic [29:0] p,
                       input logic [5:0] h);
    we = w; sel = s; din = d; exl_set = es; exl_clr = ec; pc = p; hwint = h;
    @(posedge clk);
    model_edge();
    n_txn++;
    $display("txn %0d we=%0b sel=%0d din=%h set=%0b clr=%0b pc=%h hw=%h",
             n_txn, we, sel, din, exl_set, exl_clr, pc, hwint);
    #1;
    we = 1'b0; exl_set = 1'b0; exl_clr = 1'b0;
    check_all($sformatf("c%0d", n_txn));
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    model_reset();
    n_txn++;
    $display("txn %0d async reset", n_txn);
    check_val({tag, ".int_req"}, 32'(int_req), 32'h0);
    check_all(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    // 1: reset state
    #3;
    check_all("reset");
    sel = 5'd15; #1;
    check_val("reset.prid", dout, 32'h0000_3000);
    @(negedge clk);
    rst = 1'b1;

    // 2: IM0+IE, then hwint[0]: request two edges later
    cycle(1'b1, 5'd12, 32'h0000_0401, 1'b0, 1'b0, 30'h0, 6'h00);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h01);
    check_val("t2.edge_k", 32'(int_req), 32'h0);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h01);
    check_val("t2.edge_k1", 32'(int_req), 32'h1);
    sel = 5'd13; #1;
    check_val("t2.cause", dout, 32'h0000_0400);

    // 3: interrupt entry
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 30'h0000_0C05, 6'h01);
    check_val("t3.epc", 32'(epc), 32'h0000_0C05);
    check_val("t3.int_req", 32'(int_req), 32'h0);
    sel = 5'd14; #1;
    check_val("t3.epc_rd", dout, 32'h0000_3014);
    sel = 5'd12; #1;
    check_val("t3.sr_rd", dout, 32'h0000_0403);

    // 4: eret with line still high, then drop the line
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 30'h0, 6'h01);
    check_val("t4.eret", 32'(int_req), 32'h1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h00);
    check_val("t4.drop1", 32'(int_req), 32'h1);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h00);
    check_val("t4.drop2", 32'(int_req), 32'h0);

    // 5: all three strobes at one edge
    cycle(1'b1, 5'd14, 32'hFFFF_FFFC, 1'b1, 1'b1, 30'h1, 6'h00);
    check_val("t5.epc", 32'(epc), 32'h1);
    sel = 5'd12; #1;
    check_val("t5.exl", 32'(dout[1]), 32'h1);

    // 6: async reset with live state
    cycle(1'b1, 5'd12, 32'h0000_FC03, 1'b0, 1'b0, 30'h0, 6'h3F);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h3F);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 30'h0, 6'h3F);
    async_reset("t6");
    check_val("t6.epc", 32'(epc), 32'h0);
    hwint = '0;

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [4:0]  s;
      logic [31:0] d;
      logic [5:0]  h;
      if ($urandom_range(0, 59) == 0) begin
        async_reset($sformatf("rr%0d", i));
      end else begin
        s = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(11, 16));
        d = $urandom;
        h = ($urandom_range(0, 3) == 0) ? 6'($urandom) : hwint;
        cycle(($urandom_range(0, 2) == 0), s, d,
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
              30'($urandom), h);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
